// File: rtl/regfile_wb_sched_pkg.sv
// rtl/regfile_wb_sched_pkg.sv - shared types and constants for the register-file write-back scheduler
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int NREQ       = 2;
  localparam int WB_DATA_W  = 64;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t              addr;
    logic [WB_DATA_W-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_arb.sv
// rtl/regfile_wb_sched_arb.sv - 2-way write-back arbiter; REGFILE_WB_RR_EN selects round-robin, else fixed priority (req0 wins)
module wb_rr_arb
  import regfile_pkg::*;
(
`ifdef REGFILE_WB_RR_EN
  input  logic            clk,
  input  logic            reset_n,
`endif
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] grant_o
);

`ifdef REGFILE_WB_RR_EN
  // ptr_q = 1 means req1 currently has priority
  logic ptr_q;
  logic ptr_d;

  // pick the preferred requester if it asks, otherwise the other one
  always_comb begin
    grant_o = '0;
    if (ptr_q) begin
      if (req_i[1])      grant_o[1] = 1'b1;
      else if (req_i[0]) grant_o[0] = 1'b1;
    end else begin
      if (req_i[0])      grant_o[0] = 1'b1;
      else if (req_i[1]) grant_o[1] = 1'b1;
    end
  end

  // a grant is only given to a valid requester, so every grant is an acceptance
  always_comb begin
    ptr_d = ptr_q;
    if (grant_o[0])      ptr_d = 1'b1;
    else if (grant_o[1]) ptr_d = 1'b0;
  end

  // priority pointer, reset to favour the load return path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
`else
  // load return always wins; the ALU path waits
  always_comb begin
    grant_o    = '0;
    grant_o[0] = req_i[0];
    grant_o[1] = req_i[1] & ~req_i[0];
  end
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - write-back scheduler: arbitration, registered regfile write port, pending-write scoreboard (REGFILE_WB_RR_EN: round-robin)
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NREQ-1:0]                  wb_valid,
  output logic [NREQ-1:0]                  wb_ready,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]  wb_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]      wb_data,
  input  logic                             rsv_valid,
  input  reg_addr_t                        rsv_addr,
  output reg_addr_t                        rf_wreg,
  output logic [DATA_W-1:0]                rf_wdata,
  output logic                             rf_wen,
  output logic [NUM_REGS-1:0]              busy,
  output logic                             wb_unexp
);

  logic [NREQ-1:0]     grant;
  logic                accept;
  logic                sel;
  wb_req_t             sel_req;

  wb_req_t             wr_q, wr_d;
  logic                wen_q, wen_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                unexp_q, unexp_d;

  wb_rr_arb u_arb (
`ifdef REGFILE_WB_RR_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .req_i   (wb_valid),
    .grant_o (grant)
  );

  assign wb_ready = grant;
  assign accept   = |grant;
  assign sel      = grant[1];

  // mux the granted requester onto the write port
  always_comb begin
    sel_req.addr = wb_addr[sel];
    sel_req.data = wb_data[sel];
  end

  // output stage always drains; X31 writes are acknowledged but never reach the regfile
  always_comb begin
    wr_d  = wr_q;
    wen_d = 1'b0;
    if (accept) begin
      wr_d  = sel_req;
      wen_d = (sel_req.addr != ZERO_REG);
    end
  end

  // scoreboard: clear on regfile write, then set on reservation so a new producer wins a collision
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[wr_q.addr] = 1'b0;
    if (rsv_valid && (rsv_addr != ZERO_REG)) busy_d[rsv_addr] = 1'b1;
    unexp_d = unexp_q | (wen_q & ~busy_q[wr_q.addr]);
  end

  // state registers; reset drops any write still in the output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      wen_q   <= 1'b0;
      busy_q  <= '0;
      unexp_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      unexp_q <= unexp_d;
    end
  end

  assign rf_wreg  = wr_q.addr;
  assign rf_wdata = wr_q.data;
  assign rf_wen   = wen_q;
  assign busy     = busy_q;
  assign wb_unexp = unexp_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - scoreboard bench for regfile_wb_sched (honours REGFILE_WB_RR_EN)
module tb_regfile_wb_sched;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       wb_valid;
  logic [1:0]       wb_ready;
  logic [1:0][4:0]  wb_addr;
  logic [1:0][63:0] wb_data;
  logic             rsv_valid;
  logic [4:0]       rsv_addr;
  logic [4:0]       rf_wreg;
  logic [63:0]      rf_wdata;
  logic             rf_wen;
  logic [31:0]      busy;
  logic             wb_unexp;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  logic [1:0] exp_grant[$];
  wr_t        exp_wr[$];
  logic [1:0] mon_g;
  wr_t        mon_w;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [63:0] DA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DB = 64'hFEDC_BA98_7654_3210;

  regfile_wb_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rf_wreg   (rf_wreg),
    .rf_wdata  (rf_wdata),
    .rf_wen    (rf_wen),
    .busy      (busy),
    .wb_unexp  (wb_unexp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [63:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  // monitor: pops expectations whenever the DUT grants or writes
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (wb_ready != 2'b00) begin
        if (exp_grant.size() == 0) check("grant_unexpected", 64'(wb_ready), 64'd0);
        else begin
          mon_g = exp_grant.pop_front();
          check("grant", 64'(wb_ready), 64'(mon_g));
        end
      end
      if (rf_wen) begin
        if (exp_wr.size() == 0) check("write_unexpected", 64'(rf_wen), 64'd0);
        else begin
          mon_w = exp_wr.pop_front();
          check("rf_wreg", 64'(rf_wreg), 64'(mon_w.a));
          check("rf_wdata", rf_wdata, mon_w.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    wb_valid  = 2'b00;
    wb_addr   = '0;
    wb_data   = '0;
    rsv_valid = 1'b0;
    rsv_addr  = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_rf_wreg", 64'(rf_wreg), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_unexp", 64'(wb_unexp), 64'd0);
    reset_n = 1'b1;

    // single write: reserve X5, ALU writes it two cycles later
    step(); rsv_valid = 1'b1; rsv_addr = 5'd5;
    step(); rsv_valid = 1'b0;
    check("sw_busy5_c1", 64'(busy[5]), 64'd1);
    step(); wb_valid = 2'b10; wb_addr[1] = 5'd5; wb_data[1] = 64'hDEAD_BEEF;
    exp_grant.push_back(2'b10); push_wr(5'd5, 64'hDEAD_BEEF);
    step(); wb_valid = 2'b00;
    check("sw_wen_c3", 64'(rf_wen), 64'd1);
    check("sw_wreg_c3", 64'(rf_wreg), 64'd5);
    check("sw_busy5_c3", 64'(busy[5]), 64'd1);
    step();
    check("sw_busy5_c4", 64'(busy[5]), 64'd0);
    check("sw_wen_c4", 64'(rf_wen), 64'd0);

    // zero register: reservation ignored, write acknowledged but dropped
    rsv_valid = 1'b1; rsv_addr = 5'd31;
    step(); rsv_valid = 1'b0;
    check("x31_busy_rsv", 64'(busy), 64'd0);
    wb_valid = 2'b01; wb_addr[0] = 5'd31; wb_data[0] = 64'd1;
    exp_grant.push_back(2'b01);
    step(); wb_valid = 2'b00;
    check("x31_wen", 64'(rf_wen), 64'd0);
    step();
    check("x31_busy", 64'(busy), 64'd0);
    check("x31_wen2", 64'(rf_wen), 64'd0);

    // set/clear collision on X7
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    step(); rsv_valid = 1'b0;
    wb_valid = 2'b10; wb_addr[1] = 5'd7; wb_data[1] = 64'd77;
    exp_grant.push_back(2'b10); push_wr(5'd7, 64'd77);
    step(); wb_valid = 2'b00; rsv_valid = 1'b1; rsv_addr = 5'd7;
    check("col_wen", 64'(rf_wen), 64'd1);
    step(); rsv_valid = 1'b0;
    check("col_busy7", 64'(busy[7]), 64'd1);
    check("col_unexp", 64'(wb_unexp), 64'd0);
    step();
    check("col_busy7_hold", 64'(busy[7]), 64'd1);

    // unexpected write to X9 (never reserved)
    wb_valid = 2'b01; wb_addr[0] = 5'd9; wb_data[0] = 64'd9;
    exp_grant.push_back(2'b01); push_wr(5'd9, 64'd9);
    step(); wb_valid = 2'b00;
    check("unexp_before", 64'(wb_unexp), 64'd0);
    check("unexp_wen", 64'(rf_wen), 64'd1);
    step();
    check("unexp_set", 64'(wb_unexp), 64'd1);
    step(); step();
    check("unexp_held", 64'(wb_unexp), 64'd1);

    // contention: both valid, five acceptances; fifth write is lost to reset
    wb_valid = 2'b11;
    wb_addr[0] = 5'd12; wb_data[0] = DA;
    wb_addr[1] = 5'd13; wb_data[1] = DB;
    rsv_valid = 1'b1; rsv_addr = 5'd20;
    for (int i = 0; i < 5; i++) begin
`ifdef REGFILE_WB_RR_EN
      exp_grant.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      if (i < 4) begin
        if (i % 2 == 0) push_wr(5'd12, DA);
        else            push_wr(5'd13, DB);
      end
`else
      exp_grant.push_back(2'b01);
      if (i < 4) push_wr(5'd12, DA);
`endif
      step();
      rsv_valid = 1'b0;
    end
    check("pre_rst_busy20", 64'(busy[20]), 64'd1);
    check("pre_rst_unexp", 64'(wb_unexp), 64'd1);
    check("pre_rst_wen", 64'(rf_wen), 64'd1);

    // reset mid-stream with both requesters still valid
    reset_n = 1'b0;
    #1;
    check("mrst_wen", 64'(rf_wen), 64'd0);
    check("mrst_wreg", 64'(rf_wreg), 64'd0);
    check("mrst_wdata", rf_wdata, 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_unexp", 64'(wb_unexp), 64'd0);
    step(); step();
    exp_grant.push_back(2'b01); push_wr(5'd12, DA);
    reset_n = 1'b1;
    step(); wb_valid = 2'b00;
    check("post_rst_wen", 64'(rf_wen), 64'd1);
    step(); step();
    check("grant_q_empty", 64'(exp_grant.size()), 64'd0);
    check("write_q_empty", 64'(exp_wr.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
